// File: rtl/dma_ctrl_pkg.sv
// Shared types for the DMA command initiator.
// AW/LW fix the widths of the command descriptor that travels through the FIFO.
package dma_ctrl_pkg;
  localparam int AW = 32;
  localparam int LW = 16;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

  typedef enum logic [1:0] {
    CPL_OK       = 2'd0,
    CPL_TIMEOUT  = 2'd1,
    CPL_ZERO_LEN = 2'd2
  } cpl_status_e;

  typedef struct packed {
    logic [AW-1:0] src;
    logic [AW-1:0] dst;
    logic [LW-1:0] len;
  } dma_cmd_t;
endpackage

// File: rtl/dma_cmd_fifo.sv
// Synchronous command FIFO of dma_cmd_t.
// Ports: clk, rst (sync, active high) | push/wdata write side, ignored when full |
//        pop/rdata read side, rdata is the current head, pop ignored when empty |
//        full/empty status.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module dma_cmd_fifo
  import dma_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  dma_cmd_t wdata,
  input  logic     pop,
  output dma_cmd_t rdata,
  output logic     full,
  output logic     empty
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] PTR_ONE = 1;

  dma_cmd_t        mem [DEPTH];
  logic     [PW:0] wptr, rptr;

  assign empty = (wptr == rptr);
  assign full  = (wptr[PW] != rptr[PW]) && (wptr[PW-1:0] == rptr[PW-1:0]);
  assign rdata = mem[rptr[PW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full) wptr <= wptr + PTR_ONE;
      if (pop && !empty) rptr <= rptr + PTR_ONE;
    end
  end

  // Storage needs no reset: the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wptr[PW-1:0]] <= wdata;
  end
endmodule

// File: rtl/dma_cmd_initiator.sv
// Initiator side of the DMA start/done handshake.
// Ports: clk, rst (sync, active high) |
//        cmd_valid/cmd_ready/cmd_src/cmd_dst/cmd_len  command intake (valid/ready) |
//        dma_start/dma_src/dma_dst/dma_len/dma_done  engine handshake |
//        busy  work pending or in flight |
//        cpl_valid/cpl_status/cpl_count  per-command completion reporting.
// Commands are buffered, popped one at a time in IDLE, held on dma_start until
// done (or the watchdog fires), then DRAIN waits for done to fall.
// AW/LW must match the package descriptor widths.
module dma_cmd_initiator #(
  parameter int AW          = 32,
  parameter int LW          = 16,
  parameter int DEPTH       = 4,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [AW-1:0] cmd_src,
  input  logic [AW-1:0] cmd_dst,
  input  logic [LW-1:0] cmd_len,
  output logic          dma_start,
  output logic [AW-1:0] dma_src,
  output logic [AW-1:0] dma_dst,
  output logic [LW-1:0] dma_len,
  input  logic          dma_done,
  output logic          busy,
  output logic          cpl_valid,
  output logic [1:0]    cpl_status,
  output logic [15:0]   cpl_count
);
  import dma_ctrl_pkg::*;

  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] TLAST   = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] TCNT_ONE = 1;

  state_e      state, state_d;
  dma_cmd_t    head, cur;
  logic        full, empty, pop;
  logic        start_d, cpl_v_d;
  cpl_status_e cpl_s, cpl_s_d;
  logic [TW-1:0] tcnt, tcnt_d;

  dma_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd_valid),
    .wdata ({cmd_src, cmd_dst, cmd_len}),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  assign cmd_ready  = !full;
  assign busy       = (state != IDLE) || !empty;
  assign dma_src    = cur.src;
  assign dma_dst    = cur.dst;
  assign dma_len    = cur.len;
  assign cpl_status = cpl_s;

  always_comb begin
    state_d = state;
    start_d = dma_start;
    cpl_v_d = 1'b0;
    cpl_s_d = cpl_s;
    tcnt_d  = tcnt;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          if (head.len != '0) begin
            start_d = 1'b1;
            state_d = ISSUE;
          end else begin
            // Zero-length work completes immediately without touching the engine.
            cpl_v_d = 1'b1;
            cpl_s_d = CPL_ZERO_LEN;
          end
        end
      end
      ISSUE: begin
        // done is checked first so it wins a tie with the watchdog.
        if (dma_done) begin
          start_d = 1'b0;
          cpl_v_d = 1'b1;
          cpl_s_d = CPL_OK;
          state_d = DRAIN;
        end else if (tcnt == TLAST) begin
          start_d = 1'b0;
          cpl_v_d = 1'b1;
          cpl_s_d = CPL_TIMEOUT;
          state_d = DRAIN;
        end else begin
          tcnt_d = tcnt + TCNT_ONE;
        end
      end
      DRAIN: begin
        if (!dma_done) begin
          state_d = IDLE;
          tcnt_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      dma_start <= 1'b0;
      cpl_valid <= 1'b0;
      cpl_s     <= CPL_OK;
      cpl_count <= '0;
      tcnt      <= '0;
      cur       <= '0;
    end else begin
      state     <= state_d;
      dma_start <= start_d;
      cpl_valid <= cpl_v_d;
      cpl_s     <= cpl_s_d;
      tcnt      <= tcnt_d;
      if (pop) cur <= head;
      // Count moves with the pulse so the new value is seen alongside cpl_valid.
      if (cpl_v_d) cpl_count <= cpl_count + 16'd1;
    end
  end
endmodule

// File: tb/tb_dma_cmd_initiator.sv
// Randomised bench for dma_cmd_initiator with a transaction-level scoreboard.
module tb_dma_cmd_initiator;
  localparam int TO = 256;

  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    logic [15:0] len;
  } mcmd_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_src, cmd_dst;
  logic [15:0] cmd_len;
  logic        dma_start;
  logic [31:0] dma_src, dma_dst;
  logic [15:0] dma_len;
  logic        dma_done;
  logic        busy;
  logic        cpl_valid;
  logic [1:0]  cpl_status;
  logic [15:0] cpl_count;

  always #5 clk = ~clk;

  dma_cmd_initiator #(.AW(32), .LW(16), .DEPTH(4), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len),
    .dma_start(dma_start), .dma_src(dma_src), .dma_dst(dma_dst), .dma_len(dma_len),
    .dma_done(dma_done), .busy(busy),
    .cpl_valid(cpl_valid), .cpl_status(cpl_status), .cpl_count(cpl_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model state
  mcmd_t exp_q[$];   // accepted commands awaiting completion, in order
  int    d_q[$];     // engine done-delay chosen for each started command
  int    f_q[$];     // forced delays for directed tests
  int    model_cnt = 0;
  bit    mon_en = 0;
  int    last_wait;

  // Engine answers d cycles after start: start-high length d+1 unless the
  // watchdog (TO cycles) gets there first.
  function automatic int exp_dur(input int d);
    return (d <= TO - 1) ? d + 1 : TO;
  endfunction
  function automatic int exp_st(input int d);
    return (d <= TO - 1) ? 0 : 1;
  endfunction
  function automatic int pick_d();
    int r;
    r = $urandom_range(0, 99);
    if (r < 80) return $urandom_range(1, 20);
    if (r < 90) return TO - 1;
    return 1000;
  endfunction

  // Engine model
  initial begin
    dma_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (dma_start) begin
        int d;
        d = (f_q.size() > 0) ? f_q.pop_front() : pick_d();
        d_q.push_back(d);
        for (int c = 0; c < d && dma_start; c++) begin @(posedge clk); #1; end
        if (dma_start) begin
          dma_done = 1'b1;
          repeat ($urandom_range(1, 3)) @(posedge clk);
          #1 dma_done = 1'b0;
        end
      end
    end
  end

  // Monitor / scoreboard
  bit prev_start = 0;
  int hi = 0, gap = 100, cur_d = -1;
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (dma_start && !prev_start) begin
        chk("start_gap", gap >= 2, 1);
        chk("start_has_cmd", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          chk("dma_src", dma_src, exp_q[0].src);
          chk("dma_dst", dma_dst, exp_q[0].dst);
          chk("dma_len", dma_len, exp_q[0].len);
        end
        cur_d = (d_q.size() > 0) ? d_q.pop_front() : -1;
        hi = 1;
      end else if (dma_start) begin
        hi++;
      end
      if (!dma_start && prev_start) begin
        chk("start_high_cycles", hi, exp_dur(cur_d));
        gap = 1;
      end else if (!dma_start) begin
        gap++;
      end
      if (cpl_valid) begin
        chk("cpl_has_cmd", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          if (exp_q[0].len == 16'd0) begin
            chk("cpl_status_zero", cpl_status, 2);
          end else begin
            chk("cpl_status", cpl_status, exp_st(cur_d));
            chk("cpl_at_start_fall", prev_start && !dma_start, 1);
          end
          void'(exp_q.pop_front());
        end
        model_cnt = (model_cnt + 1) % 65536;
        chk("cpl_count", cpl_count, model_cnt);
      end
    end
    prev_start = dma_start;
  end

  // Offer one command starting at a negedge; returns one negedge after acceptance.
  task automatic send(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l);
    int w;
    w = 0;
    cmd_valid = 1'b1; cmd_src = s; cmd_dst = d; cmd_len = l;
    while (!cmd_ready && w < 2000) begin @(negedge clk); w++; end
    last_wait = w;
    if (w >= 2000) begin
      chk("send_accepted", 0, 1);
      cmd_valid = 1'b0;
    end else begin
      exp_q.push_back('{src: s, dst: d, len: l});
      @(negedge clk);
      cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 5000) begin @(negedge clk); n++; end
    chk(tag, (exp_q.size() == 0) && !busy, 1);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_src = '0; cmd_dst = '0; cmd_len = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_dma_start", dma_start, 0);
    chk("rst_cpl_valid", cpl_valid, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_cpl_count", cpl_count, 0);
    chk("rst_dma_src", dma_src, 0);
    mon_en = 1;

    // Single command, done 10 cycles after start
    f_q.push_back(10);
    send(32'h1000, 32'h2000, 16'd64);
    chk("lat_edge_k", dma_start, 0);
    @(negedge clk);
    chk("lat_edge_k1", dma_start, 1);
    wait_idle("single_idle");
    chk("single_cnt", cpl_count, 1);

    // Burst into the FIFO; the sixth offer must stall while full
    for (int i = 0; i < 6; i++) f_q.push_back(20);
    for (int i = 0; i < 6; i++) send(32'h100 * i, 32'h8000 + i, 16'(i + 1));
    chk("burst_full_stall", last_wait > 0, 1);
    wait_idle("burst_idle");

    // Watchdog expiry then next queued command
    f_q.push_back(1000); f_q.push_back(8);
    send(32'hA0, 32'hB0, 16'd16);
    send(32'hA1, 32'hB1, 16'd32);
    wait_idle("timeout_idle");

    // done lands on the watchdog cycle
    f_q.push_back(TO - 1);
    send(32'hC0, 32'hD0, 16'd4);
    wait_idle("tie_idle");

    // Zero length followed by a real one
    f_q.push_back(5);
    send(32'hE0, 32'hF0, 16'd0);
    send(32'hE1, 32'hF1, 16'd8);
    wait_idle("zero_idle");
    chk("zero_cnt", cpl_count, 12);

    // Random traffic
    for (int i = 0; i < 30; i++) begin
      logic [15:0] l;
      l = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 4096));
      send($urandom, $urandom, l);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_idle("rand_idle");

    // Reset while issuing with two commands queued
    f_q.push_back(1000);
    send(32'h11, 32'h22, 16'd1);
    send(32'h33, 32'h44, 16'd2);
    send(32'h55, 32'h66, 16'd3);
    begin
      int n;
      n = 0;
      while (!dma_start && n < 20) begin @(negedge clk); n++; end
      chk("rst_test_started", dma_start, 1);
    end
    repeat (3) @(negedge clk);
    mon_en = 0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_dma_start", dma_start, 0);
    chk("mid_rst_cpl_valid", cpl_valid, 0);
    chk("mid_rst_cmd_ready", cmd_ready, 1);
    chk("mid_rst_cpl_count", cpl_count, 0);
    exp_q.delete(); d_q.delete(); f_q.delete();
    model_cnt = 0; gap = 100;
    begin
      int starts;
      int cpls;
      starts = 0; cpls = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (dma_start) starts++;
        if (cpl_valid) cpls++;
      end
      chk("post_rst_no_start", starts, 0);
      chk("post_rst_no_cpl", cpls, 0);
    end
    chk("final_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
